// File: rtl/dram_arbiter_if.sv
// Bundle of external-port, core and DRAM-side signals around the DRAM arbiter.
// The arbiter connects through slave; the cores, external port and DRAM model connect through master.
interface dram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              ext_en;
    logic              ext_we;
    logic              ext_re;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_valid;

    logic              c1_req;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_ack;
    logic [DATA_W-1:0] c1_rdata;

    logic              c2_req;
    logic              c2_we;
    logic [ADDR_W-1:0] c2_addr;
    logic [DATA_W-1:0] c2_wdata;
    logic              c2_ack;
    logic [DATA_W-1:0] c2_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  ext_en, ext_we, ext_re, ext_addr, ext_wdata,
        output ext_rdata, ext_valid,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        output c1_ack, c1_rdata,
        input  c2_req, c2_we, c2_addr, c2_wdata,
        output c2_ack, c2_rdata,
        output mem_addr, mem_we, mem_wdata, busy,
        input  mem_rdata
    );

    modport master (
        output ext_en, ext_we, ext_re, ext_addr, ext_wdata,
        input  ext_rdata, ext_valid,
        output c1_req, c1_we, c1_addr, c1_wdata,
        input  c1_ack, c1_rdata,
        output c2_req, c2_we, c2_addr, c2_wdata,
        input  c2_ack, c2_rdata,
        input  mem_addr, mem_we, mem_wdata, busy,
        output mem_rdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// Shares one DRAM between core 1, core 2 (round-robin) and the external load/readback port.
// Latency: IDLE->ACC->[WAIT x RD_LAT-1]->RSP, ack/valid registered out of RSP; cores hold req until ack.
module dram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    dram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, WAIT, RSP} state_t;
    typedef enum logic [1:0] {OWN_C1, OWN_C2, OWN_EXT} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              we_prev_q, we_prev_d, re_prev_q, re_prev_d;
    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d, c2_rdata_q, c2_rdata_d, ext_rdata_q, ext_rdata_d;
    logic              c1_ack_q, c1_ack_d, c2_ack_q, c2_ack_d, ext_valid_q, ext_valid_d;
    logic              busy_q, busy_d;
    logic              we_rise, re_rise, pick_c2;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        we_prev_d   = bus.ext_we;
        re_prev_d   = bus.ext_re;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        c1_rdata_d  = c1_rdata_q;
        c2_rdata_d  = c2_rdata_q;
        ext_rdata_d = ext_rdata_q;
        c1_ack_d    = 1'b0;
        c2_ack_d    = 1'b0;
        ext_valid_d = 1'b0;
        we_rise     = bus.ext_we & ~we_prev_q;
        re_rise     = bus.ext_re & ~re_prev_q;
        // rr_q=1 means core 2 wins a tie
        pick_c2     = bus.c2_req & (~bus.c1_req | rr_q);

        case (state_q)
            IDLE: begin
                if (bus.ext_en && (wr_pend_q || rd_pend_q)) begin
                    owner_d     = OWN_EXT;
                    we_d        = wr_pend_q;
                    mem_we_d    = wr_pend_q;
                    mem_addr_d  = bus.ext_addr;
                    mem_wdata_d = bus.ext_wdata;
                    if (wr_pend_q) wr_pend_d = 1'b0;
                    else           rd_pend_d = 1'b0;
                    state_d     = ACC;
                end else if (!bus.ext_en && (bus.c1_req || bus.c2_req)) begin
                    owner_d     = pick_c2 ? OWN_C2 : OWN_C1;
                    we_d        = pick_c2 ? bus.c2_we : bus.c1_we;
                    mem_we_d    = pick_c2 ? bus.c2_we : bus.c1_we;
                    mem_addr_d  = pick_c2 ? bus.c2_addr : bus.c1_addr;
                    mem_wdata_d = pick_c2 ? bus.c2_wdata : bus.c1_wdata;
                    state_d     = ACC;
                end
            end
            ACC: begin
                if (we_q || RD_LAT == 1) begin
                    state_d = RSP;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = RSP;
            end
            RSP: begin
                case (owner_q)
                    OWN_C1: begin
                        if (!we_q) c1_rdata_d = bus.mem_rdata;
                        c1_ack_d = 1'b1;
                        rr_d     = 1'b1;
                    end
                    OWN_C2: begin
                        if (!we_q) c2_rdata_d = bus.mem_rdata;
                        c2_ack_d = 1'b1;
                        rr_d     = 1'b0;
                    end
                    default: begin
                        if (!we_q) ext_rdata_d = bus.mem_rdata;
                        ext_valid_d = 1'b1;
                    end
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge in the cycle a pending op is served must not be lost
        if (we_rise)      wr_pend_d = 1'b1;
        else if (re_rise) rd_pend_d = 1'b1;
        if (!bus.ext_en) begin
            wr_pend_d = 1'b0;
            rd_pend_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_C1;
            we_q        <= 1'b0;
            cnt_q       <= 2'd0;
            rr_q        <= 1'b0;
            we_prev_q   <= 1'b0;
            re_prev_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            c1_rdata_q  <= '0;
            c2_rdata_q  <= '0;
            ext_rdata_q <= '0;
            c1_ack_q    <= 1'b0;
            c2_ack_q    <= 1'b0;
            ext_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            we_prev_q   <= we_prev_d;
            re_prev_q   <= re_prev_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            c1_rdata_q  <= c1_rdata_d;
            c2_rdata_q  <= c2_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            c1_ack_q    <= c1_ack_d;
            c2_ack_q    <= c2_ack_d;
            ext_valid_q <= ext_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.c1_rdata  = c1_rdata_q;
    assign bus.c2_rdata  = c2_rdata_q;
    assign bus.ext_rdata = ext_rdata_q;
    assign bus.c1_ack    = c1_ack_q;
    assign bus.c2_ack    = c2_ack_q;
    assign bus.ext_valid = ext_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a RD_LAT=3 synchronous DRAM model.
module tb_dram_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   c1_ack_cnt = 0, c2_ack_cnt = 0, ext_valid_cnt = 0, mem_we_cnt = 0;

    dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] dram [1 << ADDR_W];
    logic [DATA_W-1:0] rd_pipe [3];

    always @(posedge clock) begin
        if (bus.mem_we) dram[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe[0] <= dram[bus.mem_addr];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    always @(negedge clock) begin
        if (bus.c1_ack)    c1_ack_cnt++;
        if (bus.c2_ack)    c2_ack_cnt++;
        if (bus.ext_valid) ext_valid_cnt++;
        if (bus.mem_we)    mem_we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic core_start(input int n, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd);
        if (n == 1) begin
            bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wd; bus.c1_req = 1'b1;
        end else begin
            bus.c2_we = we; bus.c2_addr = addr; bus.c2_wdata = wd; bus.c2_req = 1'b1;
        end
    endtask

    // n=3 waits for ext_valid; core req is dropped in the ack cycle
    task automatic wait_ack(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (n == 1 && bus.c1_ack)    seen = 1'b1;
            if (n == 2 && bus.c2_ack)    seen = 1'b1;
            if (n == 3 && bus.ext_valid) seen = 1'b1;
        end
        if (n == 1) bus.c1_req = 1'b0;
        if (n == 2) bus.c2_req = 1'b0;
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int snap, snap2;
        int grants[$];
        bus.ext_en = 0; bus.ext_we = 0; bus.ext_re = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.c1_req = 0; bus.c1_we = 0; bus.c1_addr = '0; bus.c1_wdata = '0;
        bus.c2_req = 0; bus.c2_we = 0; bus.c2_addr = '0; bus.c2_wdata = '0;

        // 1: reset with c1_req high, then first ack on the third edge
        core_start(1, 1'b1, 9'd3, 16'h0011);
        repeat (3) @(negedge clock);
        check("rst_ctl", {27'd0, bus.busy, bus.mem_we, bus.c1_ack, bus.c2_ack, bus.ext_valid}, 32'd0);
        check("rst_mem", {7'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
        check("rst_rdata", {bus.c1_rdata, bus.c2_rdata}, 32'd0);
        check("rst_ext_rdata", 32'(bus.ext_rdata), 32'd0);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            check($sformatf("rst_ack_e%0d", e), 32'(bus.c1_ack), (e == 3) ? 32'd1 : 32'd0);
        end
        bus.c1_req = 1'b0;
        @(negedge clock);

        // 2: c1 write then read back; c2_rdata untouched
        snap = mem_we_cnt;
        core_start(1, 1'b1, 9'd5, 16'h00AB);
        wait_ack(1, "wr5_ack");
        check("wr5_we_pulses", 32'(mem_we_cnt - snap), 32'd1);
        core_start(1, 1'b0, 9'd5, 16'h0000);
        wait_ack(1, "rd5_ack");
        check("rd5_c1_rdata", 32'(bus.c1_rdata), 32'h00AB);
        check("rd5_c2_rdata", 32'(bus.c2_rdata), 32'h0000);
        check("rd5_no_write", 32'(mem_we_cnt - snap), 32'd1);

        // 3: both cores held, grants alternate starting with c1
        do_reset();
        core_start(1, 1'b1, 9'd20, 16'h1111);
        core_start(2, 1'b1, 9'd21, 16'h2222);
        for (int i = 0; i < 100 && grants.size() < 8; i++) begin
            @(negedge clock);
            if (bus.c1_ack) grants.push_back(1);
            if (bus.c2_ack) grants.push_back(2);
        end
        bus.c1_req = 1'b0; bus.c2_req = 1'b0;
        check("rr_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        repeat (4) @(negedge clock);

        // 4: external port: held ext_we gives one write, ext_re reads it back
        snap = mem_we_cnt; snap2 = ext_valid_cnt;
        bus.ext_en = 1'b1; bus.ext_addr = 9'd1; bus.ext_wdata = 16'd7; bus.ext_we = 1'b1;
        repeat (4) @(negedge clock);
        bus.ext_we = 1'b0;
        repeat (8) @(negedge clock);
        check("ext_we_once", 32'(mem_we_cnt - snap), 32'd1);
        check("ext_wr_valid", 32'(ext_valid_cnt - snap2), 32'd1);
        bus.ext_re = 1'b1;
        @(negedge clock);
        bus.ext_re = 1'b0;
        wait_ack(3, "ext_rd_valid");
        check("ext_rdata", 32'(bus.ext_rdata), 32'd7);
        bus.ext_en = 1'b0;
        repeat (3) @(negedge clock);

        // 5: ext_en rises while c2 read waits; c1 held off until ext_en falls
        core_start(2, 1'b0, 9'd1, 16'h0000);
        repeat (2) @(negedge clock);
        check("wait_busy", 32'(bus.busy), 32'd1);
        bus.ext_en = 1'b1;
        core_start(1, 1'b0, 9'd5, 16'h0000);
        wait_ack(2, "c2_ack_in_ext");
        check("c2_rdata_in_ext", 32'(bus.c2_rdata), 32'd7);
        snap = c1_ack_cnt;
        repeat (12) @(negedge clock);
        check("c1_held_off", 32'(c1_ack_cnt - snap), 32'd0);
        bus.ext_en = 1'b0;
        wait_ack(1, "c1_after_ext");
        check("c1_rdata_after_ext", 32'(bus.c1_rdata), 32'h00AB);
        repeat (3) @(negedge clock);

        // 6: async reset in ACC of a c1 write
        core_start(1, 1'b1, 9'd30, 16'h3333);
        @(posedge clock); #1;
        check("abort_in_acc", 32'(bus.mem_we), 32'd1);
        snap = c1_ack_cnt;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        bus.c1_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("abort_no_ack", 32'(c1_ack_cnt - snap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
